iob_ram_sp_arbiter: RTL and testbench
=====================================

// Module: iob_ram_sp_arbiter
// PURPOSE
//  Shares one single-port RAM (en/we/addr/din/dout, 1-cycle registered read) between two requesters.
//  Each requester issues reads/writes over valid/ready; reads return over a valid/ready response channel.
//  Round-robin grant, one RAM access per cycle. Per-requester 2-entry response FIFO gives full read throughput.
//  Sits between cache/engine logic and the single-port RAM instance.
// PARAMETERS
//  DATA_W  8   RAM word width
//  ADDR_W  14  RAM address width
// PORTS
//  ap_clk        in   1       clock; all state updates on rising edge
//  areset        in   1       asynchronous, active-high reset
//  req_valid_i   in   2       bit n: requester n presents a request
//  req_ready_o   out  2       bit n: requester n's request is accepted this cycle
//  req_we_i      in   2       bit n: 1 = write, 0 = read
//  req_addr_i    in   2*ADDR_W  requester n's address in bits [n*ADDR_W +: ADDR_W]
//  req_din_i     in   2*DATA_W  requester n's write data, same packing
//  rsp_valid_o   out  2       bit n: read data available for requester n
//  rsp_ready_i   in   2       bit n: requester n takes its response
//  rsp_dout_o    out  2*DATA_W  read data, same packing
//  ram_en_o      out  1       to RAM en
//  ram_we_o      out  1       to RAM we
//  ram_addr_o    out  ADDR_W  to RAM addr
//  ram_din_o     out  DATA_W  to RAM din
//  ram_dout_i    in   DATA_W  from RAM dout; valid the cycle after a read edge
// BEHAVIOUR
//  - Reset (async assert, sync release): rr_ptr=0 (requester 0 preferred), both FIFOs empty, pend=0.
//    While areset: req_ready_o=0, rsp_valid_o=0, ram_en_o=0, ram_we_o=0. Data outputs are don't-care.
//  - Eligibility of requester n:
//    - Write: always eligible.
//    - Read: eligible iff pend[n] + fifo_cnt[n] - (rsp_valid_o[n]&rsp_ready_i[n]) < 2.
//  - Grant, combinational:
//    - If only one eligible valid requester: grant it.
//    - If both: grant rr_ptr.
//    - On any contended grant, rr_ptr <= loser. Uncontended grants leave rr_ptr unchanged.
//  - req_ready_o[n] = grant[n]. At most one bit set. Never asserted for an ineligible request.
//  - RAM drive, combinational from the granted request:
//    - ram_en_o = |grant; ram_we_o = granted we; ram_addr_o/ram_din_o = granted addr/din.
//    - No grant -> ram_en_o=0, ram_we_o=0.
//  - Write committed at the accepting edge k. No response generated.
//  - Read accepted at edge k: pend[n]=1, pend_id=n. RAM dout valid after edge k.
//    At edge k+1 ram_dout_i is pushed into FIFO n and pend cleared (unless a new read re-sets it).
//    rsp_valid_o[n] rises after edge k+1: 2-cycle accept-to-response latency.
//  - Response FIFO (per requester): 2 entries; rsp_valid_o = !empty; rsp_dout_o = head.
//    Pop on rsp_valid&rsp_ready. Simultaneous push and pop is legal; count unchanged.
//    Overflow is impossible by eligibility rule; bench asserts it.
//  - Ordering:
//    - Accesses hit the RAM in grant order, so a read granted after a write to the same address returns the new data.
//    - Responses per requester are in request order.
//  - Back-to-back reads by one requester at 1/cycle sustain with rsp_ready held 1.
//    With rsp_ready=0, at most 2 reads are accepted, then req_ready_o[n] stays 0 (requester n reads only) until a pop.
//  - Requester n's writes are still granted while its reads are blocked (no head-of-line coupling).
//  - req_* inputs must stay stable while valid && !ready. The block does not latch unaccepted requests.
//  - areset mid-read: pending read and FIFO contents discarded; no response emitted after release.
// TESTING
//  - Reset:
//    - Stimulus: assert areset during traffic.
//    - Required response: req_ready_o=0, rsp_valid_o=0, ram_en_o=0 immediately.
//    - After release: first contended grant goes to requester 0.
//  - Write then read, requester 0:
//    - Stimulus: write addr 0x0005 data 0xA5; next cycle read addr 0x0005.
//    - Required response: rsp_dout_o[7:0]=0xA5, rsp_valid_o[0] exactly 2 cycles after read acceptance.
//  - Contention:
//    - Stimulus: both requesters hold reads valid for 6 cycles.
//    - Required response: grants alternate 0,1,0,1,0,1; ram_en_o=1 every cycle; each requester gets 3 responses in order.
//  - Back-pressure:
//    - Stimulus: requester 1 reads addrs 1,2,3 with rsp_ready_i[1]=0.
//    - Required response: only addrs 1,2 accepted; addr 3 accepted the cycle rsp_ready_i[1] rises; data order 1,2,3.
//  - Write while read-blocked:
//    - Stimulus: requester 0 has a full response FIFO and issues a write to addr 0x0010 data 0x3C.
//    - Required response: write granted; a later read of 0x0010 returns 0x3C.
//  - Reset mid-read:
//    - Stimulus: areset pulse 1 cycle after a read is accepted.
//    - Required response: no rsp_valid_o for that read after release.

Source files
------------

// File: rtl/iob_ram_sp_arbiter.sv
// -----------------------------------------------------------------------------
// iob_ram_sp_arbiter
//
// Shares one single-port RAM (1-cycle registered read) between two requesters.
// Each requester issues reads and writes over a request channel. Read data
// comes back over a per-requester response channel. Grants are round-robin and
// the RAM sees at most one access per cycle. Each requester owns a 2-entry
// response FIFO, so back-to-back reads run at full rate while the response
// side keeps up.
//
// Handshake semantics (request and response channels alike): a transfer
// happens on a rising ap_clk edge where valid and ready are both 1. A
// requester keeps its request fields stable while valid is 1 and ready is 0.
// ready may depend combinationally on valid. The block does not latch
// requests that have not been accepted.
//
// Ports
//   ap_clk       clock, rising edge
//   areset       asynchronous, active-high reset
//   req_valid_i  [1:0]        request present, bit n = requester n
//   req_ready_o  [1:0]        request accepted this cycle (one-hot or zero)
//   req_we_i     [1:0]        1 = write, 0 = read
//   req_addr_i   [2*ADDR_W]   requester n address at [n*ADDR_W +: ADDR_W]
//   req_din_i    [2*DATA_W]   requester n write data, same packing
//   rsp_valid_o  [1:0]        read data waiting for requester n
//   rsp_ready_i  [1:0]        requester n takes its response
//   rsp_dout_o   [2*DATA_W]   read data, same packing
//   ram_en_o/ram_we_o/ram_addr_o/ram_din_o  RAM command, combinational
//   ram_dout_i   RAM read data, valid the cycle after the read edge
// -----------------------------------------------------------------------------
module iob_ram_sp_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_din_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [2*DATA_W-1:0]   rsp_dout_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_din_o,
  input  logic [DATA_W-1:0]     ram_dout_i
);

  // Round-robin pointer: the requester that wins the next contended cycle.
  logic rr_ptr_q, rr_ptr_d;

  // One RAM read can be in flight at a time (one access per cycle), so a
  // single pending flag plus the owner id describes it completely.
  logic pend_q, pend_d;
  logic pend_id_q, pend_id_d;

  // Response FIFOs: 2 entries each, 1-bit read/write pointers, 2-bit count.
  logic [DATA_W-1:0] mem_q [2][2];
  logic [1:0]        cnt_q [2];
  logic [1:0]        cnt_d [2];
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;

  logic [1:0] push;   // pending read lands in FIFO n at the coming edge
  logic [1:0] pop;    // response n handed over at the coming edge
  logic [1:0] occ [2];
  logic [1:0] elig;
  logic [1:0] cand;
  logic [1:0] grant;
  logic       gsel;   // index of the granted requester when grant != 0

  // ---------------------------------------------------------------------------
  // FIFO status and response outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    push        = '0;
    pop         = '0;
    rsp_valid_o = '0;
    rsp_dout_o  = '0;
    for (int n = 0; n < 2; n++) begin
      push[n]        = pend_q && (pend_id_q == 1'(n));
      rsp_valid_o[n] = (cnt_q[n] != 2'd0);
      pop[n]         = rsp_valid_o[n] && rsp_ready_i[n];
      rsp_dout_o[n*DATA_W +: DATA_W] = mem_q[n][rd_ptr_q[n]];
    end
  end

  // ---------------------------------------------------------------------------
  // Eligibility and grant
  // ---------------------------------------------------------------------------
  // A read is eligible only if, counting the in-flight read and crediting a
  // pop that happens on the same edge, the FIFO still has room for it. Writes
  // produce no response, so they never wait on the response path.
  always_comb begin
    elig = '0;
    for (int n = 0; n < 2; n++) begin
      occ[n]  = {1'b0, push[n]} + cnt_q[n] - {1'b0, pop[n]};
      elig[n] = req_we_i[n] || (occ[n] < 2'd2);
    end
    cand = req_valid_i & elig & {2{~areset}};
    if (&cand) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant = cand;
    end
    gsel        = grant[1];
    req_ready_o = grant;
  end

  // ---------------------------------------------------------------------------
  // RAM command, straight from the granted request
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en_o   = |grant;
    ram_we_o   = (|grant) && req_we_i[gsel];
    ram_addr_o = gsel ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
    ram_din_o  = gsel ? req_din_i[DATA_W +: DATA_W]  : req_din_i[0 +: DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // The winner of a contended cycle hands priority to the loser; grants
    // without contention leave the pointer alone.
    rr_ptr_d  = (&cand) ? ~rr_ptr_q : rr_ptr_q;
    // A new read re-arms the pending flag in the same edge the previous one
    // is pushed, giving 1 read per cycle.
    pend_d    = (|grant) && !req_we_i[gsel];
    pend_id_d = pend_d ? gsel : pend_id_q;
    rd_ptr_d  = rd_ptr_q ^ pop;
    wr_ptr_d  = wr_ptr_q ^ push;
    for (int n = 0; n < 2; n++) begin
      cnt_d[n] = cnt_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      rr_ptr_q  <= 1'b0;
      pend_q    <= 1'b0;
      pend_id_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q[0]  <= 2'd0;
      cnt_q[1]  <= 2'd0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  // FIFO storage needs no reset: entries are only visible when the count
  // says so, and the count is reset.
  always_ff @(posedge ap_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][wr_ptr_q[n]] <= ram_dout_i;
      end
    end
  end

endmodule

// File: tb/tb_iob_ram_sp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iob_ram_sp_arbiter
//
// Bench for iob_ram_sp_arbiter with a behavioural single-port RAM attached.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Sections: vector table, randomized traffic against a
// transaction-level model, then directed multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_iob_ram_sp_arbiter;

  localparam int DW = 8;
  localparam int AW = 14;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ap_clk = 1'b0;
  logic areset = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready_o;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_din = '0;
  logic [1:0]      rsp_valid_o;
  logic [1:0]      rsp_ready = 2'b11;
  logic [2*DW-1:0] rsp_dout_o;
  logic            ram_en_o;
  logic            ram_we_o;
  logic [AW-1:0]   ram_addr_o;
  logic [DW-1:0]   ram_din_o;
  logic [DW-1:0]   ram_dout = '0;

  iob_ram_sp_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_din_i   (req_din),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_dout_o  (rsp_dout_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_din_o   (ram_din_o),
    .ram_dout_i  (ram_dout)
  );

  // Single-port RAM, registered read.
  logic [DW-1:0] ram_mem [16384] = '{default: 8'h00};
  always @(posedge ap_clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] <= ram_din_o;
      else          ram_dout <= ram_mem[ram_addr_o];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge ap_clk);
  endtask

  task automatic set_req(input int n, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[n]        = v;
    req_we[n]           = w;
    req_addr[n*AW +: AW] = a;
    req_din[n*DW +: DW]  = d;
  endtask

  // Uncontended single write through the DUT.
  task automatic wr(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(n, 1'b1, 1'b1, a, d);
    smp();
    chk("wr_ready", 32'(req_ready_o[n]), 32'd1);
    next();
    set_req(n, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    areset = 1'b0;
    next();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]    v;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    e_rdy;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
  } vec_t;

  vec_t tbl [10];

  // Random-phase model state: per-requester expected responses with the
  // cycle of acceptance, the shadow contents of the random address window,
  // and the round-robin preference.
  logic [DW-1:0] exp_q [2][$];
  int            acc_q [2][$];
  logic [DW-1:0] shadow [16];
  logic          rr_m;
  logic [1:0]    acc_last;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, i0, i1, win;
    logic [1:0] pop_m, cand_m, gnt_m;
    logic expv;

    tbl[0] = '{2'b00, 2'b00, 14'h00, 14'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 14'h00, 8'h00};
    tbl[1] = '{2'b01, 2'b01, 14'h20, 14'h00, 8'h11, 8'h00, 2'b01, 1'b1, 1'b1, 14'h20, 8'h11};
    tbl[2] = '{2'b10, 2'b10, 14'h00, 14'h21, 8'h00, 8'h22, 2'b10, 1'b1, 1'b1, 14'h21, 8'h22};
    tbl[3] = '{2'b11, 2'b11, 14'h22, 14'h23, 8'h33, 8'h44, 2'b01, 1'b1, 1'b1, 14'h22, 8'h33};
    tbl[4] = '{2'b11, 2'b11, 14'h24, 14'h25, 8'h55, 8'h66, 2'b10, 1'b1, 1'b1, 14'h25, 8'h66};
    tbl[5] = '{2'b01, 2'b00, 14'h20, 14'h00, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 14'h20, 8'h00};
    tbl[6] = '{2'b11, 2'b01, 14'h26, 14'h21, 8'h77, 8'h00, 2'b01, 1'b1, 1'b1, 14'h26, 8'h77};
    tbl[7] = '{2'b11, 2'b10, 14'h22, 14'h27, 8'h00, 8'h88, 2'b10, 1'b1, 1'b1, 14'h27, 8'h88};
    tbl[8] = '{2'b11, 2'b00, 14'h22, 14'h23, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 14'h22, 8'h00};
    tbl[9] = '{2'b00, 2'b00, 14'h00, 14'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 14'h00, 8'h00};

    // ---- reset state ----
    #2;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_ram_en", 32'(ram_en_o), 32'd0);
    do_reset();

    // ---- vector table ----
    for (int t = 0; t < 10; t++) begin
      req_valid = tbl[t].v;
      req_we    = tbl[t].we;
      req_addr  = {tbl[t].a1, tbl[t].a0};
      req_din   = {tbl[t].d1, tbl[t].d0};
      smp();
      chk($sformatf("tbl%0d_ready", t), 32'(req_ready_o), 32'(tbl[t].e_rdy));
      chk($sformatf("tbl%0d_en", t), 32'(ram_en_o), 32'(tbl[t].e_en));
      chk($sformatf("tbl%0d_we", t), 32'(ram_we_o), 32'(tbl[t].e_we));
      if (tbl[t].e_en) chk($sformatf("tbl%0d_addr", t), 32'(ram_addr_o), 32'(tbl[t].e_addr));
      if (tbl[t].e_we) chk($sformatf("tbl%0d_din", t), 32'(ram_din_o), 32'(tbl[t].e_din));
      next();
    end
    repeat (4) next();

    // ---- randomized traffic against the transaction model ----
    do_reset();
    rr_m     = 1'b0;
    acc_last = '0;
    for (int i = 0; i < 16; i++) shadow[i] = ram_mem[14'h100 + 14'(i)];
    for (int p = 0; p < 400; p++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n] || acc_last[n]) begin
          set_req(n, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  14'h100 + 14'($urandom_range(0, 15)), 8'($urandom));
        end
      end
      rsp_ready = 2'($urandom);
      smp();
      cand_m = '0;
      for (int n = 0; n < 2; n++) begin
        // A response becomes visible two cycles after its read was accepted.
        expv = (exp_q[n].size() != 0) && (acc_q[n][0] + 2 <= p);
        chk($sformatf("rnd_rsp_valid%0d", n), 32'(rsp_valid_o[n]), 32'(expv));
        if (expv) chk($sformatf("rnd_rsp_dout%0d", n), 32'(rsp_dout_o[n*DW +: DW]), 32'(exp_q[n][0]));
        pop_m[n] = expv && rsp_ready[n];
        cand_m[n] = req_valid[n] &&
                    (req_we[n] || (exp_q[n].size() - int'(pop_m[n]) < 2));
      end
      if (cand_m == 2'b11) begin
        win  = int'(rr_m);
        rr_m = !rr_m;
      end else begin
        win = cand_m[1] ? 1 : 0;
      end
      gnt_m = (cand_m == 2'b00) ? 2'b00 : 2'(1 << win);
      chk("rnd_ready", 32'(req_ready_o), 32'(gnt_m));
      chk("rnd_ram_en", 32'(ram_en_o), 32'(gnt_m != 2'b00));
      if (gnt_m != 2'b00) begin
        chk("rnd_ram_addr", 32'(ram_addr_o), 32'(req_addr[win*AW +: AW]));
        chk("rnd_ram_we", 32'(ram_we_o), 32'(req_we[win]));
        if (req_we[win]) chk("rnd_ram_din", 32'(ram_din_o), 32'(req_din[win*DW +: DW]));
      end
      for (int n = 0; n < 2; n++) begin
        if (pop_m[n]) begin
          void'(exp_q[n].pop_front());
          void'(acc_q[n].pop_front());
        end
      end
      if (gnt_m != 2'b00) begin
        if (req_we[win]) begin
          shadow[req_addr[win*AW +: 4]] = req_din[win*DW +: DW];
        end else begin
          exp_q[win].push_back(shadow[req_addr[win*AW +: 4]]);
          acc_q[win].push_back(p);
        end
      end
      acc_last = gnt_m;
      next();
    end

    // ---- reset asserted during traffic ----
    set_req(0, 1'b1, 1'b0, 14'h101, 8'h00);
    set_req(1, 1'b1, 1'b0, 14'h102, 8'h00);
    rsp_ready = 2'b00;
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_ram_en", 32'(ram_en_o), 32'd0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    req_valid = '0;
    rsp_ready = 2'b11;
    @(negedge ap_clk);
    areset = 1'b0;
    next();
    smp();
    chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    next();

    // ---- contention: both requesters read for 6 cycles ----
    for (int i = 0; i < 3; i++) begin
      wr(0, 14'h200 + 14'(i), 8'hA0 + 8'(i));
      wr(1, 14'h210 + 14'(i), 8'hB0 + 8'(i));
    end
    i0 = 0; i1 = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 10; c++) begin
      set_req(0, c < 6, 1'b0, 14'h200 + 14'(i0), 8'h00);
      set_req(1, c < 6, 1'b0, 14'h210 + 14'(i1), 8'h00);
      smp();
      if (c < 6) begin
        chk($sformatf("cont%0d_ready", c), 32'(req_ready_o), (c % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("cont%0d_ram_en", c), 32'(ram_en_o), 32'd1);
        if (c % 2 == 0) i0++; else i1++;
      end
      if (rsp_valid_o[0]) begin
        chk($sformatf("cont_rsp0_%0d", n0), 32'(rsp_dout_o[0 +: DW]), 32'(8'hA0 + 8'(n0)));
        n0++;
      end
      if (rsp_valid_o[1]) begin
        chk($sformatf("cont_rsp1_%0d", n1), 32'(rsp_dout_o[DW +: DW]), 32'(8'hB0 + 8'(n1)));
        n1++;
      end
      next();
    end
    chk("cont_rsp0_count", 32'(n0), 32'd3);
    chk("cont_rsp1_count", 32'(n1), 32'd3);

    // ---- back-pressure on requester 1 ----
    wr(1, 14'h0001, 8'h11);
    wr(1, 14'h0002, 8'h22);
    wr(1, 14'h0003, 8'h33);
    rsp_ready = 2'b01;
    i1 = 1;
    for (int c = 0; c < 5; c++) begin
      set_req(1, 1'b1, 1'b0, 14'(i1), 8'h00);
      smp();
      chk($sformatf("bp%0d_ready", c), 32'(req_ready_o[1]), (c < 2) ? 32'd1 : 32'd0);
      if (c < 2) i1++;
      next();
    end
    rsp_ready = 2'b11;
    smp();
    chk("bp_release_ready", 32'(req_ready_o[1]), 32'd1);
    chk("bp_rsp_a", 32'(rsp_dout_o[DW +: DW]), 32'h11);
    next();
    set_req(1, 1'b0, 1'b0, '0, '0);
    smp();
    chk("bp_valid_b", 32'(rsp_valid_o[1]), 32'd1);
    chk("bp_rsp_b", 32'(rsp_dout_o[DW +: DW]), 32'h22);
    next();
    smp();
    chk("bp_valid_c", 32'(rsp_valid_o[1]), 32'd1);
    chk("bp_rsp_c", 32'(rsp_dout_o[DW +: DW]), 32'h33);
    next();
    smp();
    chk("bp_empty", 32'(rsp_valid_o[1]), 32'd0);
    next();

    // ---- write while requester 0 is read-blocked ----
    wr(0, 14'h0300, 8'h5A);
    wr(0, 14'h0301, 8'h5B);
    rsp_ready = 2'b10;
    for (int c = 0; c < 2; c++) begin
      set_req(0, 1'b1, 1'b0, 14'h0300 + 14'(c), 8'h00);
      smp();
      chk($sformatf("blk_rd%0d_ready", c), 32'(req_ready_o[0]), 32'd1);
      next();
    end
    set_req(0, 1'b1, 1'b1, 14'h0010, 8'h3C);
    smp();
    chk("blk_wr_ready", 32'(req_ready_o[0]), 32'd1);
    chk("blk_wr_we", 32'(ram_we_o), 32'd1);
    chk("blk_wr_addr", 32'(ram_addr_o), 32'h0010);
    next();
    set_req(0, 1'b1, 1'b0, 14'h0010, 8'h00);
    for (int c = 0; c < 2; c++) begin
      smp();
      chk($sformatf("blk_rd_held%0d", c), 32'(req_ready_o[0]), 32'd0);
      next();
    end
    rsp_ready = 2'b11;
    smp();
    chk("blk_release_ready", 32'(req_ready_o[0]), 32'd1);
    chk("blk_rsp_a", 32'(rsp_dout_o[0 +: DW]), 32'h5A);
    next();
    set_req(0, 1'b0, 1'b0, '0, '0);
    smp();
    chk("blk_rsp_b", 32'(rsp_dout_o[0 +: DW]), 32'h5B);
    next();
    smp();
    chk("blk_valid_c", 32'(rsp_valid_o[0]), 32'd1);
    chk("blk_rsp_c", 32'(rsp_dout_o[0 +: DW]), 32'h3C);
    next();

    // ---- write then read, requester 0, two-cycle latency ----
    set_req(0, 1'b1, 1'b1, 14'h0005, 8'hA5);
    smp();
    chk("wr5_ready", 32'(req_ready_o), 32'd1);
    next();
    set_req(0, 1'b1, 1'b0, 14'h0005, 8'h00);
    smp();
    chk("rd5_ready", 32'(req_ready_o), 32'd1);
    next();
    set_req(0, 1'b0, 1'b0, '0, '0);
    smp();
    chk("rd5_lat1_valid", 32'(rsp_valid_o[0]), 32'd0);
    next();
    smp();
    chk("rd5_lat2_valid", 32'(rsp_valid_o[0]), 32'd1);
    chk("rd5_dout", 32'(rsp_dout_o[0 +: DW]), 32'hA5);
    next();
    smp();
    chk("rd5_popped", 32'(rsp_valid_o[0]), 32'd0);
    next();

    // ---- reset one cycle after a read is accepted ----
    set_req(0, 1'b1, 1'b0, 14'h0005, 8'h00);
    smp();
    chk("rstrd_ready", 32'(req_ready_o), 32'd1);
    next();
    set_req(0, 1'b0, 1'b0, '0, '0);
    areset = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    areset = 1'b0;
    next();
    for (int c = 0; c < 4; c++) begin
      smp();
      chk($sformatf("rstrd_no_rsp%0d", c), 32'(rsp_valid_o), 32'd0);
      next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
